sobel_window_buffer: RTL and testbench
======================================

Name: sobel_window_buffer

Overview:
- Streaming 3x3 neighbourhood generator directly upstream of the Sobel edge-detection stage in the user domain.
- Accepts one signed 8-bit grayscale pixel per handshake in raster order.
- Stores two previous image rows in line buffers and emits the six non-centre-column pixels (p00, p02, p10, p12, p20, p22) that the gradient stage consumes, with valid/ready flow control and frame tracking.

Parameters:
- IMG_WIDTH, 64, pixels per row; must be >= 3.
- IMG_HEIGHT, 64, rows per frame; must be >= 3.
- CW, 16, width of coordinate outputs; must satisfy 2**CW > max(IMG_WIDTH, IMG_HEIGHT).

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- pix_valid_i  input  1  input pixel valid.
- pix_ready_o  output  1  block can accept a pixel.
- pix_data_i  input  8  signed grayscale pixel.
- sof_i  input  1  start of frame; qualifies pixel (0,0), sampled with pix_valid_i.
- win_valid_o  output  1  window outputs valid.
- win_ready_i  input  1  downstream accepts window.
- p00_o, p02_o, p10_o, p12_o, p20_o, p22_o  output  8 each  signed window pixels; row 0 = oldest row, column 0 = leftmost column.
- win_x_o  output  CW  column of window centre pixel.
- win_y_o  output  CW  row of window centre pixel.
- frame_done_o  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset: all outputs 0, except pix_ready_o = 1. State = IDLE; row and column counters = 0; line-buffer contents are don't-care.
- Input accept: pix_valid_i && pix_ready_o. Set pix_ready_o = !win_valid_o || win_ready_i.
- State machine:
  - IDLE: an accepted pixel with sof_i goes to FILL at position (0,0). An accepted pixel without sof_i is dropped; state unchanged.
  - FILL: holds while rows 0-1 are accepted; moves to ACTIVE when the row counter reaches 2.
  - ACTIVE: on acceptance of pixel (IMG_HEIGHT-1, IMG_WIDTH-1), go to IDLE and pulse frame_done_o for the next cycle.
- Counters: col increments per accepted pixel and wraps to 0 after IMG_WIDTH-1; row increments on col wrap.
- Line buffers: two arrays, each IMG_WIDTH x 8. On accepting pixel P at column c:
  - read lb0[c] (row r-1) and lb1[c] (row r-2);
  - write lb1[c] <= lb0[c] and lb0[c] <= P.
- Column shift registers: three rows, each 3 deep. On every accept, shift in (lb1[c], lb0[c], P).
- Window emission:
  - The window is produced on the cycle after accepting pixel (r,c) with r >= 2 and c >= 2.
  - Outputs registered: p00=(r-2,c-2), p02=(r-2,c), p10=(r-1,c-2), p12=(r-1,c), p20=(r,c-2), p22=(r,c).
  - win_x_o = c-1, win_y_o = r-1.
  - Latency: 1 cycle. Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Output hold: while win_valid_o && !win_ready_i, all window outputs are held stable. No input is accepted, so no data is lost.
- win_valid_o clears after the handshake unless a new window is loaded in the same cycle (back-to-back throughput of 1 per cycle).
- Columns 0-1 of each row produce no window. Row wrap does not need a buffer flush, because shift-register stale data is never emitted.
- sof_i on an accepted pixel in FILL or ACTIVE: the frame restarts. That pixel becomes (0,0), state goes to FILL, and no frame_done_o pulse is issued. A pending window output is still held until it is accepted.
- Reset mid-frame: same as power-up reset; any pending window is discarded.
- Values pass through unmodified; no arithmetic is performed on pixel data.

Optional Feature:
- Macro: SOBEL_WIN_STATS_EN.
- Defined:
  - Adds output drop_cnt_o (16 bits), counting pixels dropped in IDLE. It saturates at 0xFFFF and clears on reset.
  - Adds output restart_cnt_o (8 bits), counting mid-frame sof_i restarts. It saturates at 0xFF and clears on reset.
- Undefined: neither port nor the counter logic exists; functionality is otherwise identical.

Test Plan:
- Basic frame, IMG_WIDTH=4, IMG_HEIGHT=4. Stream pixels value = 4*row+col with sof_i on the first pixel and win_ready_i = 1.
  - Exactly 4 windows.
  - First: p00=0, p02=2, p10=4, p12=6, p20=8, p22=10 with win_x_o=1, win_y_o=1.
  - Last: p00=5, p02=7, p10=9, p12=11, p20=13, p22=15 with (2,2).
  - frame_done_o pulses once.
- Backpressure: hold win_ready_i = 0 for 3 cycles while win_valid_o = 1.
  - Outputs remain unchanged and pix_ready_o = 0.
  - After release, the window sequence is identical to the basic frame.
- Pre-SOF drop: send 5 pixels without sof_i, then a normal frame.
  - The first 5 pixels are ignored; windows match the basic frame.
  - With SOBEL_WIN_STATS_EN, drop_cnt_o = 5.
- Mid-frame restart: assert sof_i on pixel 6 of a frame, then send a full frame from that pixel.
  - No window carries pre-restart data; windows match the basic frame; no extra frame_done_o pulse.
- Reset mid-frame: assert rst_i for 1 cycle after 9 pixels.
  - All outputs are 0 and pix_ready_o = 1.
  - The next full frame produces the basic-frame windows.
- Throughput: continuous valid/ready, 2 back-to-back frames.
  - 8 windows and 2 frame_done_o pulses, with no bubbles beyond columns 0-1 and rows 0-1.

Source files
------------

// File: rtl/sobel_window_buffer.sv
// sobel_window_buffer
// Streaming 3x3 neighbourhood generator feeding a Sobel gradient stage.
// Two line buffers hold the previous two rows. Three 3-deep column shift
// registers hold the current window. Only the six non-centre-column pixels
// are presented downstream, with valid/ready flow control.
// Optional build macro: SOBEL_WIN_STATS_EN adds the drop_cnt_o and
// restart_cnt_o statistics outputs.
module sobel_window_buffer #(
   parameter int IMG_WIDTH  = 64,
   parameter int IMG_HEIGHT = 64,
   parameter int CW         = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              pix_valid_i,
   output logic              pix_ready_o,
   input  logic signed [7:0] pix_data_i,
   input  logic              sof_i,
   output logic              win_valid_o,
   input  logic              win_ready_i,
   output logic signed [7:0] p00_o,
   output logic signed [7:0] p02_o,
   output logic signed [7:0] p10_o,
   output logic signed [7:0] p12_o,
   output logic signed [7:0] p20_o,
   output logic signed [7:0] p22_o,
   output logic [CW-1:0]     win_x_o,
   output logic [CW-1:0]     win_y_o,
   output logic              frame_done_o
`ifdef SOBEL_WIN_STATS_EN
   ,
   output logic [15:0]       drop_cnt_o,
   output logic [7:0]        restart_cnt_o
`endif
);

   typedef logic signed [7:0] pix_t;
   typedef enum logic [1:0] {IDLE, FILL, ACTIVE} state_e;

   localparam int            AW       = $clog2(IMG_WIDTH);
   localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
   localparam logic [CW-1:0] LAST_ROW = CW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] TWO      = CW'(2);

   state_e        state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [CW-1:0] row_q, row_d;
   logic [CW-1:0] win_x_q, win_x_d;
   logic [CW-1:0] win_y_q, win_y_d;
   logic          win_valid_q, win_valid_d;
   logic          frame_done_q, frame_done_d;

   // Column shift registers: element [0] is column c, [2] is column c-2.
   // Row 0 is the oldest image row (r-2), row 2 is the current row (r).
   pix_t [2:0]    sr0_q, sr0_d;
   pix_t [2:0]    sr1_q, sr1_d;
   pix_t [2:0]    sr2_q, sr2_d;

   // lb0 holds row r-1, lb1 holds row r-2, indexed by column.
   pix_t          lb0_mem [IMG_WIDTH];
   pix_t          lb1_mem [IMG_WIDTH];

   logic          accept;
   logic          process;
   logic [CW-1:0] cur_col;
   logic [CW-1:0] cur_row;
   logic [AW-1:0] col_idx;
   pix_t          lb0_rd;
   pix_t          lb1_rd;
   logic          last_pix;

   // A pixel is taken whenever the output register is free or being emptied.
   assign pix_ready_o = !win_valid_q || win_ready_i;
   assign accept      = pix_valid_i && pix_ready_o;

   // Pixel position: sof forces the accepted pixel to (0,0) in any state.
   always_comb begin
      process  = accept && (sof_i || (state_q != IDLE));
      cur_col  = sof_i ? '0 : col_q;
      cur_row  = sof_i ? '0 : row_q;
      col_idx  = cur_col[AW-1:0];
      lb0_rd   = lb0_mem[col_idx];
      lb1_rd   = lb1_mem[col_idx];
      last_pix = (cur_row == LAST_ROW) && (cur_col == LAST_COL);
   end

   // Next-state, counters, shift registers and window load.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      win_x_d      = win_x_q;
      win_y_d      = win_y_q;
      win_valid_d  = win_valid_q && !win_ready_i;
      frame_done_d = 1'b0;
      sr0_d        = sr0_q;
      sr1_d        = sr1_q;
      sr2_d        = sr2_q;

      if (process) begin
         sr0_d = {sr0_q[1:0], lb1_rd};
         sr1_d = {sr1_q[1:0], lb0_rd};
         sr2_d = {sr2_q[1:0], pix_data_i};
         if (cur_col == LAST_COL) begin
            col_d = '0;
            row_d = cur_row + 1'b1;
         end else begin
            col_d = cur_col + 1'b1;
            row_d = cur_row;
         end
         // Columns 0-1 and rows 0-1 never complete a window, so stale
         // shift-register contents from the previous row are never emitted.
         if ((cur_row >= TWO) && (cur_col >= TWO)) begin
            win_valid_d = 1'b1;
            win_x_d     = cur_col - 1'b1;
            win_y_d     = cur_row - 1'b1;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (process) state_d = FILL;
         end
         FILL: begin
            if (process && (row_d == TWO)) state_d = ACTIVE;
         end
         ACTIVE: begin
            if (process) begin
               if (sof_i) begin
                  state_d = FILL;
               end else if (last_pix) begin
                  state_d      = IDLE;
                  row_d        = '0;
                  frame_done_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         col_q        <= '0;
         row_q        <= '0;
         win_x_q      <= '0;
         win_y_q      <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         sr0_q        <= '0;
         sr1_q        <= '0;
         sr2_q        <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         win_x_q      <= win_x_d;
         win_y_q      <= win_y_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
         sr0_q        <= sr0_d;
         sr1_q        <= sr1_d;
         sr2_q        <= sr2_d;
      end
   end

   // Line buffers: age the column by one row and store the new pixel.
   always_ff @(posedge clk_i) begin
      // NOTE: line-buffer storage is not reset; rows 0-1 of a frame rewrite it
      // before any window reads it, and leaving it unreset lets it map to RAM.
      if (process) begin
         lb1_mem[col_idx] <= lb0_rd;
         lb0_mem[col_idx] <= pix_data_i;
      end
   end

   assign win_valid_o  = win_valid_q;
   assign frame_done_o = frame_done_q;
   assign win_x_o      = win_x_q;
   assign win_y_o      = win_y_q;
   // The shift registers only move on accepts, and no accept happens while a
   // window is stalled, so their taps hold still exactly when required.
   assign p00_o        = sr0_q[2];
   assign p02_o        = sr0_q[0];
   assign p10_o        = sr1_q[2];
   assign p12_o        = sr1_q[0];
   assign p20_o        = sr2_q[2];
   assign p22_o        = sr2_q[0];

`ifdef SOBEL_WIN_STATS_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic [7:0]  restart_cnt_q, restart_cnt_d;

   // Saturating counters for pixels dropped in IDLE and mid-frame restarts.
   always_comb begin
      drop_cnt_d    = drop_cnt_q;
      restart_cnt_d = restart_cnt_q;
      if (accept && !sof_i && (state_q == IDLE) && (drop_cnt_q != 16'hFFFF))
         drop_cnt_d = drop_cnt_q + 1'b1;
      if (accept && sof_i && (state_q != IDLE) && (restart_cnt_q != 8'hFF))
         restart_cnt_d = restart_cnt_q + 1'b1;
   end

   // Statistics registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         drop_cnt_q    <= '0;
         restart_cnt_q <= '0;
      end else begin
         drop_cnt_q    <= drop_cnt_d;
         restart_cnt_q <= restart_cnt_d;
      end
   end

   assign drop_cnt_o    = drop_cnt_q;
   assign restart_cnt_o = restart_cnt_q;
`else
   // Default build: no statistics counters exist.
`endif

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Testbench for sobel_window_buffer on a 4x4 image. A negedge monitor keeps
// an image-level reference model (pixel stored at its raster position, a
// window is expected whenever row and column are both >= 2) and checks every
// window handshake and every stalled cycle against it.
module tb_sobel_window_buffer;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int CW = 16;

   typedef struct packed {
      logic signed [7:0] p00, p02, p10, p12, p20, p22;
      logic [CW-1:0]     x, y;
   } win_t;

   logic              clk;
   logic              rst_i;
   logic              pix_valid_i;
   logic              pix_ready_o;
   logic signed [7:0] pix_data_i;
   logic              sof_i;
   logic              win_valid_o;
   logic              win_ready_i;
   logic signed [7:0] p00_o, p02_o, p10_o, p12_o, p20_o, p22_o;
   logic [CW-1:0]     win_x_o, win_y_o;
   logic              frame_done_o;
`ifdef SOBEL_WIN_STATS_EN
   logic [15:0]       drop_cnt_o;
   logic [7:0]        restart_cnt_o;
`endif

   sobel_window_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CW(CW)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
      .pix_data_i(pix_data_i), .sof_i(sof_i),
      .win_valid_o(win_valid_o), .win_ready_i(win_ready_i),
      .p00_o(p00_o), .p02_o(p02_o), .p10_o(p10_o), .p12_o(p12_o),
      .p20_o(p20_o), .p22_o(p22_o),
      .win_x_o(win_x_o), .win_y_o(win_y_o), .frame_done_o(frame_done_o)
`ifdef SOBEL_WIN_STATS_EN
      , .drop_cnt_o(drop_cnt_o), .restart_cnt_o(restart_cnt_o)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model state.
   logic signed [7:0] img [H][W];
   bit                in_frame;
   int                mr, mc;
   win_t              exp_q[$];
   win_t              win_log[$];
   int                frames_exp, frames_seen, drops_exp, restarts_exp, cyc;
   int                n_cmp, n_bad;
   bit                rnd_ready, rnd_gap, stall_req, stall_taken, stall_done;

   function automatic void model_accept(input logic signed [7:0] d, input logic s);
      win_t w;
      if (s) begin
         if (in_frame) restarts_exp++;
         in_frame = 1'b1;
         mr = 0;
         mc = 0;
      end
      if (!in_frame) begin
         drops_exp++;
         return;
      end
      img[mr][mc] = d;
      if (mr >= 2 && mc >= 2) begin
         w.p00 = img[mr-2][mc-2];
         w.p02 = img[mr-2][mc];
         w.p10 = img[mr-1][mc-2];
         w.p12 = img[mr-1][mc];
         w.p20 = img[mr][mc-2];
         w.p22 = img[mr][mc];
         w.x   = CW'(mc - 1);
         w.y   = CW'(mr - 1);
         exp_q.push_back(w);
      end
      if (mr == H-1 && mc == W-1) begin
         frames_exp++;
         in_frame = 1'b0;
      end else if (mc == W-1) begin
         mc = 0;
         mr++;
      end else begin
         mc++;
      end
   endfunction

   task automatic monitor();
      win_t got, snap, e;
      bit   stall_prev = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         got = {p00_o, p02_o, p10_o, p12_o, p20_o, p22_o, win_x_o, win_y_o};
         if (stall_prev) begin
            n_cmp++;
            if (win_valid_o !== 1'b1 || got !== snap) begin
               n_bad++;
               $display("FAIL hold: valid=%b win=%h required valid=1 win=%h", win_valid_o, got, snap);
            end
         end
         if (win_valid_o === 1'b1 && win_ready_i === 1'b0) begin
            n_cmp++;
            if (pix_ready_o !== 1'b0) begin
               n_bad++;
               $display("FAIL stall_ready: pix_ready=%b required 0", pix_ready_o);
            end
         end
         if (frame_done_o === 1'b1) frames_seen++;
         if (rst_i) begin
            exp_q.delete();
            in_frame     = 1'b0;
            drops_exp    = 0;
            restarts_exp = 0;
            stall_prev   = 1'b0;
         end else begin
            if (win_valid_o === 1'b1 && win_ready_i === 1'b1) begin
               win_log.push_back(got);
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL window: unexpected window %h, none required", got);
               end else begin
                  e = exp_q.pop_front();
                  if (got !== e) begin
                     n_bad++;
                     $display("FAIL window: got %h required %h", got, e);
                  end
               end
            end
            if (pix_valid_i === 1'b1 && pix_ready_o === 1'b1) model_accept(pix_data_i, sof_i);
            stall_prev = (win_valid_o === 1'b1) && (win_ready_i === 1'b0);
            snap       = got;
         end
      end
   endtask

   task automatic ready_driver();
      int left = 0;
      forever begin
         @(posedge clk);
         #1;
         if (left > 0) begin
            win_ready_i = 1'b0;
            left--;
            if (left == 0) stall_done = 1'b1;
         end else if (stall_req && !stall_taken && win_valid_o === 1'b1) begin
            win_ready_i = 1'b0;
            left        = 2;
            stall_taken = 1'b1;
         end else begin
            win_ready_i = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
      end
   endtask

   // Drive one pixel and hold it until accepted; returns at posedge + 1.
   task automatic send_pix(input logic signed [7:0] d, input logic s);
      int waits = 0;
      if (rnd_gap && $urandom_range(0, 3) == 0) begin
         repeat ($urandom_range(1, 2)) @(posedge clk);
         #1;
      end
      pix_valid_i = 1'b1;
      pix_data_i  = d;
      sof_i       = s;
      @(negedge clk);
      while (pix_ready_o !== 1'b1 && waits < 100) begin
         @(negedge clk);
         waits++;
      end
      if (pix_ready_o !== 1'b1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: pix_ready=%b required 1", pix_ready_o);
      end
      @(posedge clk);
      #1;
      pix_valid_i = 1'b0;
      sof_i       = 1'b0;
   endtask

   task automatic send_frame(input bit ramp);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            send_pix(ramp ? 8'(4*r + c) : 8'($urandom), (r == 0 && c == 0));
   endtask

   task automatic drain();
      int k = 0;
      repeat (3) @(negedge clk);
      while ((exp_q.size() != 0 || win_valid_o === 1'b1) && k < 500) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (exp_q.size() != 0 || win_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL drain: pending=%0d valid=%b required 0 and 0", exp_q.size(), win_valid_o);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset(input int cycles);
      rst_i = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      rst_i = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      @(negedge clk);
      n_cmp++;
      if (pix_ready_o !== 1'b1) begin
         n_bad++;
         $display("FAIL %s_ready: got %b required 1", tag, pix_ready_o);
      end
      n_cmp++;
      if (win_valid_o !== 1'b0 || frame_done_o !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_flags: valid=%b done=%b required 0 0", tag, win_valid_o, frame_done_o);
      end
      n_cmp++;
      if ({p00_o, p02_o, p10_o, p12_o, p20_o, p22_o, win_x_o, win_y_o} !== '0) begin
         n_bad++;
         $display("FAIL %s_window: got %h required 0", tag,
                  {p00_o, p02_o, p10_o, p12_o, p20_o, p22_o, win_x_o, win_y_o});
      end
`ifdef SOBEL_WIN_STATS_EN
      n_cmp++;
      if (drop_cnt_o !== 16'd0 || restart_cnt_o !== 8'd0) begin
         n_bad++;
         $display("FAIL %s_stats: drop=%0d restart=%0d required 0 0", tag, drop_cnt_o, restart_cnt_o);
      end
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic check_counts(input string tag, input int wins, input int frames);
      n_cmp++;
      if (win_log.size() != wins) begin
         n_bad++;
         $display("FAIL %s_windows: got %0d required %0d", tag, win_log.size(), wins);
      end
      n_cmp++;
      if (frames_seen != frames) begin
         n_bad++;
         $display("FAIL %s_frame_done: got %0d required %0d", tag, frames_seen, frames);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      rst_i = 1'b0;
      check_idle_outputs("reset");
   endtask

   task automatic test_basic_frame();
      win_t first_req, last_req;
      first_req = {8'sd0, 8'sd2, 8'sd4, 8'sd6, 8'sd8, 8'sd10, 16'd1, 16'd1};
      last_req  = {8'sd5, 8'sd7, 8'sd9, 8'sd11, 8'sd13, 8'sd15, 16'd2, 16'd2};
      rnd_ready = 1'b0;
      win_log.delete();
      frames_seen = 0;
      send_frame(1'b1);
      drain();
      check_counts("basic", 4, 1);
      if (win_log.size() == 4) begin
         n_cmp++;
         if (win_log[0] !== first_req) begin
            n_bad++;
            $display("FAIL basic_first: got %h required %h", win_log[0], first_req);
         end
         n_cmp++;
         if (win_log[3] !== last_req) begin
            n_bad++;
            $display("FAIL basic_last: got %h required %h", win_log[3], last_req);
         end
      end
   endtask

   task automatic test_backpressure();
      rnd_ready = 1'b0;
      stall_req = 1'b1;
      win_log.delete();
      frames_seen = 0;
      send_frame(1'b1);
      drain();
      stall_req = 1'b0;
      n_cmp++;
      if (stall_done !== 1'b1) begin
         n_bad++;
         $display("FAIL bp_stall: stall_done=%b required 1", stall_done);
      end
      check_counts("bp", 4, 1);
   endtask

   task automatic test_pre_sof_drop();
      rnd_ready = 1'b1;
      win_log.delete();
      frames_seen = 0;
      for (int i = 0; i < 5; i++) send_pix(8'($urandom), 1'b0);
      send_frame(1'b0);
      drain();
      check_counts("drop", 4, 1);
`ifdef SOBEL_WIN_STATS_EN
      n_cmp++;
      if (drop_cnt_o !== 16'(drops_exp)) begin
         n_bad++;
         $display("FAIL drop_cnt: got %0d required %0d", drop_cnt_o, drops_exp);
      end
`endif
   endtask

   task automatic test_restart();
      rnd_ready = 1'b1;
      win_log.delete();
      frames_seen = 0;
      for (int i = 0; i < 5; i++) send_pix(8'($urandom), (i == 0));
      send_frame(1'b0);
      drain();
      check_counts("restart", 4, 1);
`ifdef SOBEL_WIN_STATS_EN
      n_cmp++;
      if (restart_cnt_o !== 8'(restarts_exp)) begin
         n_bad++;
         $display("FAIL restart_cnt: got %0d required %0d", restart_cnt_o, restarts_exp);
      end
`endif
   endtask

   task automatic test_reset_mid();
      rnd_ready = 1'b0;
      for (int i = 0; i < 9; i++) send_pix(8'($urandom), (i == 0));
      pulse_reset(1);
      check_idle_outputs("rst_mid");
      win_log.delete();
      frames_seen = 0;
      send_frame(1'b1);
      drain();
      check_counts("rst_mid", 4, 1);
   endtask

   task automatic test_back_to_back();
      int start;
      rnd_ready = 1'b0;
      rnd_gap   = 1'b0;
      win_log.delete();
      frames_seen = 0;
      start = cyc;
      send_frame(1'b0);
      send_frame(1'b0);
      n_cmp++;
      if (cyc - start != 2*W*H) begin
         n_bad++;
         $display("FAIL b2b_cycles: got %0d required %0d", cyc - start, 2*W*H);
      end
      drain();
      check_counts("b2b", 8, 2);
   endtask

   task automatic test_random_frames();
      int fe;
      rnd_ready = 1'b1;
      rnd_gap   = 1'b1;
      win_log.delete();
      frames_seen = 0;
      fe = frames_exp;
      for (int f = 0; f < 3; f++) send_frame(1'b0);
      drain();
      check_counts("random", 12, 3);
      n_cmp++;
      if (frames_exp - fe != frames_seen) begin
         n_bad++;
         $display("FAIL random_model_frames: got %0d required %0d", frames_seen, frames_exp - fe);
      end
      rnd_gap = 1'b0;
   endtask

   initial begin
      rst_i       = 1'b1;
      pix_valid_i = 1'b0;
      pix_data_i  = '0;
      sof_i       = 1'b0;
      win_ready_i = 1'b1;
      fork
         monitor();
         ready_driver();
      join_none
      test_reset();
      test_basic_frame();
      test_backpressure();
      test_pre_sof_drop();
      test_restart();
      test_reset_mid();
      test_back_to_back();
      test_random_frames();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
